mem_port_arbiter: RTL and testbench

- Memory-side responder for the processor's two memory request ports: instruction fetch (i_mem_*) and load/store queue (lsq_mem_*).
- Arbitrates between the two requesters and serializes their transactions onto one downstream memory port (pmem_*), which uses the same read/write/resp protocol.
- Returns a registered single-cycle response with read data to the requester that won the grant.

---
 rtl/mem_port_arbiter_pkg.sv | 41 ++++
 rtl/mem_port_arbiter_if.sv | 26 ++
 rtl/mem_port_arbiter_rr.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Purpose : shared types for the two-port memory arbiter (FSM states, latched request record).
// Latency : n/a (types only).
// Backpressure : n/a.
package rv32i_types;

    localparam int WIDTH = 32;
    localparam int BE_W  = WIDTH / 8;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_SERVE_I = 3'd1,
        ARB_SERVE_D = 3'd2,
        ARB_RESP_I  = 3'd3,
        ARB_RESP_D  = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic             read;
        logic             write;
        logic [BE_W-1:0]  byte_enable;
        logic [WIDTH-1:0] address;
        logic [WIDTH-1:0] wdata;
    } mem_req_t;

    // A port raising read and write together is treated as a write, so the
    // normalised record never carries both operation bits.
    function automatic mem_req_t to_req(input logic             rd,
                                        input logic             wr,
                                        input logic [BE_W-1:0]  be,
                                        input logic [WIDTH-1:0] addr,
                                        input logic [WIDTH-1:0] wd);
        mem_req_t r;
        r.read        = rd & ~wr;
        r.write       = wr;
        r.byte_enable = be;
        r.address     = addr;
        r.wdata       = wd;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose : read/write/resp memory port bundle shared by requesters and the downstream memory.
// Latency : n/a (wires only).
// Backpressure : requester holds read/write and payload until resp pulses.
// Ports : read, write, byte_enable, address, wdata (requester -> responder); resp, rdata (back).
interface mem_port_arbiter_if #(
    parameter int width = 32
);
    logic                 read;
    logic                 write;
    logic [width/8-1:0]   byte_enable;
    logic [width-1:0]     address;
    logic [width-1:0]     wdata;
    logic                 resp;
    logic [width-1:0]     rdata;

    // master issues requests, slave answers them
    modport master (
        output read, write, byte_enable, address, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, byte_enable, address, wdata,
        output resp, rdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Purpose : 2-way round-robin grant between fetch (I) and load/store (D) requesters.
// Latency : grant is combinational from req; last-grant history updates on the clock when take=1.
// Backpressure : none; caller asserts take only when it actually accepts the grant.
// Ports : clk, rst, req_i, req_d, take in; gnt_i, gnt_d out (one-hot or zero).
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic gnt_i,
    output logic gnt_d
);

    // 1 = LSQ won the most recent grant; resets to fetch so LSQ wins the first tie
    logic last_d_q;
    logic last_d_d;

    always_comb begin
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        last_d_d = last_d_q;
        if (req_i && req_d) begin
            gnt_d = ~last_d_q;
            gnt_i = last_d_q;
        end else begin
            gnt_i = req_i;
            gnt_d = req_d;
        end
        if (take && (gnt_i || gnt_d)) begin
            last_d_d = gnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : serialises fetch and load/store memory ports onto one downstream port, round-robin on ties.
// Latency : downstream latency + 2 cycles (1 grant, 1 response); one IDLE cycle between transactions.
// Backpressure : waits indefinitely for pmem.resp; requesters hold their request until their resp pulse.
// Ports : clk, rst; i_mem, lsq_mem (slave side of requesters); pmem (master to memory);
//         i_grant_count, lsq_grant_count (completed transactions, wrapping).
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     i_mem,
    mem_port_arbiter_if.slave     lsq_mem,
    mem_port_arbiter_if.master    pmem,
    output logic [31:0]           i_grant_count,
    output logic [31:0]           lsq_grant_count
);

    arb_state_t        state_q,       state_d;
    mem_req_t          req_q,         req_d;
    logic [width-1:0]  rdata_q,       rdata_d;
    logic              i_resp_q,      i_resp_d;
    logic              d_resp_q,      d_resp_d;
    logic [31:0]       i_grant_cnt_q, i_grant_cnt_d;
    logic [31:0]       d_grant_cnt_q, d_grant_cnt_d;

    mem_req_t i_req;
    mem_req_t d_req;
    logic     gnt_i;
    logic     gnt_d;
    logic     take;

    assign i_req = to_req(i_mem.read, i_mem.write, i_mem.byte_enable,
                          i_mem.address, i_mem.wdata);
    assign d_req = to_req(lsq_mem.read, lsq_mem.write, lsq_mem.byte_enable,
                          lsq_mem.address, lsq_mem.wdata);

    // requests are only looked at in IDLE, so a port still holding its
    // request during its RESP cycle cannot be re-granted from stale state
    assign take = (state_q == ARB_IDLE);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (take && (i_req.read || i_req.write)),
        .req_d (take && (d_req.read || d_req.write)),
        .take  (take),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        rdata_d       = rdata_q;
        i_resp_d      = 1'b0;
        d_resp_d      = 1'b0;
        i_grant_cnt_d = i_grant_cnt_q;
        d_grant_cnt_d = d_grant_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (gnt_i) begin
                    req_d   = i_req;
                    state_d = ARB_SERVE_I;
                end else if (gnt_d) begin
                    req_d   = d_req;
                    state_d = ARB_SERVE_D;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (pmem.resp) begin
                    rdata_d     = pmem.rdata;
                    // operation bits double as the registered pmem strobes
                    req_d.read  = 1'b0;
                    req_d.write = 1'b0;
                    if (state_q == ARB_SERVE_I) begin
                        i_resp_d      = 1'b1;
                        i_grant_cnt_d = i_grant_cnt_q + 32'd1;
                        state_d       = ARB_RESP_I;
                    end else begin
                        d_resp_d      = 1'b1;
                        d_grant_cnt_d = d_grant_cnt_q + 32'd1;
                        state_d       = ARB_RESP_D;
                    end
                end
            end
            ARB_RESP_I, ARB_RESP_D: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            req_q         <= '0;
            rdata_q       <= '0;
            i_resp_q      <= 1'b0;
            d_resp_q      <= 1'b0;
            i_grant_cnt_q <= '0;
            d_grant_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            rdata_q       <= rdata_d;
            i_resp_q      <= i_resp_d;
            d_resp_q      <= d_resp_d;
            i_grant_cnt_q <= i_grant_cnt_d;
            d_grant_cnt_q <= d_grant_cnt_d;
        end
    end

    assign pmem.read        = req_q.read;
    assign pmem.write       = req_q.write;
    assign pmem.byte_enable = req_q.byte_enable;
    assign pmem.address     = req_q.address;
    assign pmem.wdata       = req_q.wdata;

    // single captured rdata feeds both requesters; resp alone qualifies it
    assign i_mem.resp       = i_resp_q;
    assign i_mem.rdata      = rdata_q;
    assign lsq_mem.resp     = d_resp_q;
    assign lsq_mem.rdata    = rdata_q;

    assign i_grant_count    = i_grant_cnt_q;
    assign lsq_grant_count  = d_grant_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_cnt;
    logic [31:0] d_cnt;

    mem_port_arbiter_if #(.width(32)) i_bus ();
    mem_port_arbiter_if #(.width(32)) d_bus ();
    mem_port_arbiter_if #(.width(32)) p_bus ();

    mem_port_arbiter #(.width(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_mem           (i_bus),
        .lsq_mem         (d_bus),
        .pmem            (p_bus),
        .i_grant_count   (i_cnt),
        .lsq_grant_count (d_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- cycle counter, monitor, memory model ----------------
    int          cyc = 0;
    int          rd_cycles = 0;
    int          i_resp_n = 0;
    int          d_resp_n = 0;
    logic [31:0] last_i_rdata = '0;
    logic [31:0] last_d_rdata = '0;
    bit          order[$];      // 1 = LSQ response, 0 = fetch response

    logic [31:0] log_addr[$];
    logic [31:0] log_wd[$];
    logic [3:0]  log_be[$];
    logic        log_rd[$];
    logic        log_wr[$];
    int          log_cyc[$];

    bit          mem_auto = 1'b1;
    int          mem_lat = 1;
    int          mcnt = 0;
    logic [31:0] mem_data = '0;
    bit          man_pulse = 1'b0;
    logic [31:0] man_data = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (p_bus.read) rd_cycles++;
        if (i_bus.resp) begin
            i_resp_n++;
            order.push_back(1'b0);
            last_i_rdata = i_bus.rdata;
        end
        if (d_bus.resp) begin
            d_resp_n++;
            order.push_back(1'b1);
            last_d_rdata = d_bus.rdata;
        end
    end

    initial begin
        p_bus.resp  = 1'b0;
        p_bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (!mem_auto) begin
                mcnt        = 0;
                p_bus.resp  = man_pulse;
                p_bus.rdata = man_data;
            end else if (p_bus.resp) begin
                p_bus.resp = 1'b0;
                mcnt       = 0;
            end else if (p_bus.read || p_bus.write) begin
                if (mcnt == 0) begin
                    log_addr.push_back(p_bus.address);
                    log_wd.push_back(p_bus.wdata);
                    log_be.push_back(p_bus.byte_enable);
                    log_rd.push_back(p_bus.read);
                    log_wr.push_back(p_bus.write);
                    log_cyc.push_back(cyc);
                end
                mcnt++;
                if (mcnt == mem_lat) begin
                    p_bus.resp  = 1'b1;
                    p_bus.rdata = mem_data;
                end
            end
        end
    end

    // ---------------- requester helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_bus.read = 1'b0; i_bus.write = 1'b0;
        d_bus.read = 1'b0; d_bus.write = 1'b0;
        repeat (2) @(negedge clk);
        rd_cycles = 0; i_resp_n = 0; d_resp_n = 0;
        order.delete();
        log_addr.delete(); log_wd.delete(); log_be.delete();
        log_rd.delete(); log_wr.delete(); log_cyc.delete();
        rst = 1'b0;
    endtask

    task automatic req_i(input int n, input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
        for (int k = 0; k < n; k++) begin
            int t;
            i_bus.read = rd; i_bus.write = wr; i_bus.byte_enable = be;
            i_bus.address = a; i_bus.wdata = wd;
            t = 0;
            do begin @(negedge clk); t++; end while (!i_bus.resp && t < 200);
            check(tag, {31'd0, i_bus.resp}, 32'd1);
            i_bus.read = 1'b0; i_bus.write = 1'b0;
            if (k < n - 1) @(negedge clk);
        end
    endtask

    task automatic req_d(input int n, input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
        for (int k = 0; k < n; k++) begin
            int t;
            d_bus.read = rd; d_bus.write = wr; d_bus.byte_enable = be;
            d_bus.address = a; d_bus.wdata = wd;
            t = 0;
            do begin @(negedge clk); t++; end while (!d_bus.resp && t < 200);
            check(tag, {31'd0, d_bus.resp}, 32'd1);
            d_bus.read = 1'b0; d_bus.write = 1'b0;
            if (k < n - 1) @(negedge clk);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] seq;
        int          t;

        i_bus.read = 1'b0; i_bus.write = 1'b0; i_bus.byte_enable = '0;
        i_bus.address = '0; i_bus.wdata = '0;
        d_bus.read = 1'b0; d_bus.write = 1'b0; d_bus.byte_enable = '0;
        d_bus.address = '0; d_bus.wdata = '0;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_pmem_read",  {31'd0, p_bus.read},  32'd0);
        check("rst_pmem_write", {31'd0, p_bus.write}, 32'd0);
        check("rst_pmem_addr",  p_bus.address,        32'd0);
        check("rst_pmem_be",    {28'd0, p_bus.byte_enable}, 32'd0);
        check("rst_i_resp",     {31'd0, i_bus.resp},  32'd0);
        check("rst_d_resp",     {31'd0, d_bus.resp},  32'd0);
        check("rst_rdata",      i_bus.rdata,          32'd0);
        check("rst_i_cnt",      i_cnt,                32'd0);
        check("rst_d_cnt",      d_cnt,                32'd0);

        // single fetch read, 3-cycle downstream latency
        mem_lat = 3; mem_data = 32'h00A00093;
        req_i(1, 1'b1, 1'b0, 4'hF, 32'h0000_0060, 32'd0, "t1_resp");
        repeat (3) @(negedge clk);
        check("t1_addr",      log_addr[0],  32'h0000_0060);
        check("t1_rd_cycles", rd_cycles,    32'd3);
        check("t1_i_resp_n",  i_resp_n,     32'd1);
        check("t1_rdata",     last_i_rdata, 32'h00A00093);
        check("t1_d_resp_n",  d_resp_n,     32'd0);
        check("t1_i_cnt",     i_cnt,        32'd1);

        // simultaneous request right after reset: LSQ wins the first tie
        do_reset();
        mem_lat = 2; mem_data = 32'h1111_2222;
        fork
            req_i(1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'd0, "t2_i_resp");
            req_d(1, 1'b0, 1'b1, 4'hC, 32'h0000_2000, 32'hDEADBEEF, "t2_d_resp");
        join
        repeat (3) @(negedge clk);
        check("t2_n_txn",   log_addr.size(), 32'd2);
        check("t2_first_a", log_addr[0],     32'h0000_2000);
        check("t2_first_w", {31'd0, log_wr[0]}, 32'd1);
        check("t2_first_r", {31'd0, log_rd[0]}, 32'd0);
        check("t2_first_be", {28'd0, log_be[0]}, 32'hC);
        check("t2_first_wd", log_wd[0],      32'hDEADBEEF);
        check("t2_second_a", log_addr[1],    32'h0000_0100);
        check("t2_second_r", {31'd0, log_rd[1]}, 32'd1);
        check("t2_gap",     log_cyc[1] - log_cyc[0], 32'd4);
        check("t2_i_resp_n", i_resp_n, 32'd1);
        check("t2_d_resp_n", d_resp_n, 32'd1);

        // both ports continuously requesting, 1-cycle latency: strict alternation
        do_reset();
        mem_lat = 1;
        fork
            req_i(3, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'd0, "t3_i_resp");
            req_d(3, 1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'd0, "t3_d_resp");
        join
        repeat (3) @(negedge clk);
        seq = '0;
        foreach (order[k]) seq = {seq[30:0], order[k]};
        check("t3_n_resp", order.size(), 32'd6);
        check("t3_order",  seq,          32'b101010);
        check("t3_i_cnt",  i_cnt,        32'd3);
        check("t3_d_cnt",  d_cnt,        32'd3);

        // LSQ read+write together is a write
        do_reset();
        mem_lat = 1;
        req_d(1, 1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h5555_AAAA, "t4_resp");
        @(negedge clk);
        check("t4_addr",  log_addr[0], 32'h0000_0040);
        check("t4_write", {31'd0, log_wr[0]}, 32'd1);
        check("t4_read",  {31'd0, log_rd[0]}, 32'd0);

        // reset in SERVE_I, then a late pmem_resp in IDLE
        do_reset();
        mem_auto = 1'b0;
        i_bus.read = 1'b1; i_bus.write = 1'b0; i_bus.byte_enable = 4'hF;
        i_bus.address = 32'h0000_0080;
        t = 0;
        do begin @(negedge clk); t++; end while (!p_bus.read && t < 20);
        check("t5_serving", {31'd0, p_bus.read}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        i_bus.read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_read", {31'd0, p_bus.read}, 32'd0);
        check("t5_rst_addr", p_bus.address, 32'd0);
        #1 man_data = 32'h0000_0BAD; man_pulse = 1'b1;
        @(negedge clk);
        #1 man_pulse = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_no_resp",  i_resp_n,    32'd0);
        check("t5_rdata",    i_bus.rdata, 32'd0);
        check("t5_i_cnt",    i_cnt,       32'd0);
        check("t5_idle_rd",  {31'd0, p_bus.read}, 32'd0);
        mem_auto = 1'b1; mem_lat = 2; mem_data = 32'h0000_1234;
        req_i(1, 1'b1, 1'b0, 4'hF, 32'h0000_0084, 32'd0, "t5_after_resp");
        @(negedge clk);
        check("t5_after_addr",  log_addr[0],  32'h0000_0084);
        check("t5_after_rdata", last_i_rdata, 32'h0000_1234);
        check("t5_after_cnt",   i_cnt,        32'd1);

        // fetch counter wraps
        @(negedge clk);
        force dut.i_grant_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.i_grant_cnt_q;
        @(negedge clk);
        check("t6_preset", i_cnt, 32'hFFFF_FFFF);
        mem_lat = 1;
        req_i(1, 1'b1, 1'b0, 4'hF, 32'h0000_0090, 32'd0, "t6_resp");
        @(negedge clk);
        check("t6_wrap", i_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
